// File: rtl/led_display_package.sv
// Shared geometry and row type for the 64x32 LED matrix display path.
package led_display_package;

  localparam int GL_NUM_COL_PIXELS = 64;
  localparam int GL_RGB_ROW_W      = 6 * GL_NUM_COL_PIXELS;

  // One row-pair beat: {top, bot}, each half {red, green, blue}, column 0 at bit 0.
  typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;

endpackage

// File: rtl/led_display_pattern_gen.sv
// Test-pattern source for the LED matrix display driver.
// Emits one registered row-pair beat per request. The pattern is chosen by mode_in:
// off, solid colours, two-colour mixes, or a single lit column that steps across
// the panel on a slow timer.
module led_display_pattern_gen
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter bit SIMULATION   = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [3:0]              mode_in,
  output logic [GL_RGB_ROW_W-1:0] row_out,
  output logic                    row_valid_out,
  input  logic                    row_ready_in,
  output logic [3:0]              row_address_out
);

  localparam logic [3:0] MODE_OFF         = 4'd0;
  localparam logic [3:0] MODE_SOLID_RED   = 4'd1;
  localparam logic [3:0] MODE_SOLID_GREEN = 4'd2;
  localparam logic [3:0] MODE_SOLID_BLUE  = 4'd3;
  localparam logic [3:0] MODE_MIX_RG      = 4'd4;
  localparam logic [3:0] MODE_MIX_GB      = 4'd5;
  localparam logic [3:0] MODE_MIX_RB      = 4'd6;
  localparam logic [3:0] MODE_SCAN        = 4'd8;

  // Scan step period: 100 ms of real time, or a short 64-cycle step in simulation.
  localparam int STEP    = SIMULATION ? 64 : SYS_CLK_FREQ / 10;
  localparam int TIMER_W = $clog2(STEP);
  localparam int COL_W   = $clog2(GL_NUM_COL_PIXELS);

  localparam logic [TIMER_W-1:0]           TIMER_LAST = TIMER_W'(STEP - 1);
  localparam logic [GL_NUM_COL_PIXELS-1:0] ALL_ONES   = '1;
  localparam logic [GL_NUM_COL_PIXELS-1:0] COL0_ONLY  = GL_NUM_COL_PIXELS'(1);

  logic [3:0]                   mode_q;
  logic                         mode_change;
  logic                         scan_entry;
  logic [TIMER_W-1:0]           timer_q;
  logic [TIMER_W-1:0]           timer_next;
  logic [COL_W-1:0]             scan_col;
  logic [COL_W-1:0]             scan_col_next;
  logic [GL_NUM_COL_PIXELS-1:0] red_plane;
  logic [GL_NUM_COL_PIXELS-1:0] green_plane;
  logic [GL_NUM_COL_PIXELS-1:0] blue_plane;
  logic [GL_RGB_ROW_W-1:0]      row_next;

  // Detect mode changes and advance the scan timer/column; entering SCAN restarts both at 0.
  always_comb begin
    mode_change   = (mode_in != mode_q);
    scan_entry    = mode_change && (mode_in == MODE_SCAN);
    timer_next    = timer_q + TIMER_W'(1);
    scan_col_next = scan_col;
    if (scan_entry) begin
      timer_next    = '0;
      scan_col_next = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_next    = '0;
      scan_col_next = scan_col + COL_W'(1);
    end
  end

  // Build the colour planes for the incoming mode; the scan column used is the one in
  // effect after this edge, so a freshly entered SCAN shows column 0 straight away.
  always_comb begin
    red_plane   = '0;
    green_plane = '0;
    blue_plane  = '0;
    case (mode_in)
      MODE_OFF: ;
      MODE_SOLID_RED:   red_plane = ALL_ONES;
      MODE_SOLID_GREEN: green_plane = ALL_ONES;
      MODE_SOLID_BLUE:  blue_plane = ALL_ONES;
      MODE_MIX_RG: begin
        red_plane   = ALL_ONES;
        green_plane = ALL_ONES;
      end
      MODE_MIX_GB: begin
        green_plane = ALL_ONES;
        blue_plane  = ALL_ONES;
      end
      MODE_MIX_RB: begin
        red_plane  = ALL_ONES;
        blue_plane = ALL_ONES;
      end
      MODE_SCAN: begin
        red_plane   = COL0_ONLY << scan_col_next;
        green_plane = COL0_ONLY << scan_col_next;
        blue_plane  = COL0_ONLY << scan_col_next;
      end
      default: ;
    endcase
    row_next = {red_plane, green_plane, blue_plane, red_plane, green_plane, blue_plane};
  end

  // Mode register and scan timer/column state.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mode_q   <= MODE_OFF;
      timer_q  <= '0;
      scan_col <= '0;
    end else begin
      mode_q   <= mode_in;
      timer_q  <= timer_next;
      scan_col <= scan_col_next;
    end
  end

  // Output beat: valid follows ready by one cycle, data is refreshed every edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_out       <= '0;
      row_valid_out <= 1'b0;
    end else begin
      row_out       <= row_next;
      row_valid_out <= row_ready_in;
    end
  end

  // Row-pair address: restarts at 0 on any mode change, otherwise steps after each valid beat.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_address_out <= '0;
    end else if (mode_change) begin
      row_address_out <= '0;
    end else if (row_valid_out) begin
      row_address_out <= row_address_out + 4'd1;
    end
  end

endmodule

// File: tb/tb_led_display_pattern_gen.sv
// Self-checking bench for led_display_pattern_gen against a behavioural reference model.
module tb_led_display_pattern_gen;

  localparam int ROW_W = led_display_package::GL_RGB_ROW_W;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic [3:0]       mode_in;
  logic [ROW_W-1:0] row_out;
  logic             row_valid_out;
  logic             row_ready_in;
  logic [3:0]       row_address_out;

  int errors = 0;
  int checks = 0;

  // Reference model state, advanced once per rising edge.
  int               edge_n = 0;
  int               m_prev = 0;
  int               m_entry = 0;
  int               m_addr = 0;
  bit               m_valid = 1'b0;
  logic [ROW_W-1:0] m_row = '0;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ(100_000_000),
    .SIMULATION  (1'b1)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .mode_in        (mode_in),
    .row_out        (row_out),
    .row_valid_out  (row_valid_out),
    .row_ready_in   (row_ready_in),
    .row_address_out(row_address_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected row-pair from the mode table: which colours are fully lit, or one column for SCAN.
  function automatic logic [ROW_W-1:0] exp_row(input int mode, input int col);
    logic [63:0] ones;
    logic [63:0] one_col;
    logic [63:0] r;
    logic [63:0] g;
    logic [63:0] b;
    ones    = '1;
    one_col = 64'd1 << col;
    r = '0;
    g = '0;
    b = '0;
    if (mode == 1 || mode == 4 || mode == 6) r = ones;
    if (mode == 2 || mode == 4 || mode == 5) g = ones;
    if (mode == 3 || mode == 5 || mode == 6) b = ones;
    if (mode == 8) begin
      r = one_col;
      g = one_col;
      b = one_col;
    end
    return {r, g, b, r, g, b};
  endfunction

  task automatic checkOutput(input string tag);
    checks++;
    assert (row_valid_out === m_valid) else begin
      errors++;
      $error("[TB] FAIL %s valid observed=%0b expected=%0b (edge %0d)", tag, row_valid_out, m_valid, edge_n);
    end
    checks++;
    assert (row_address_out === 4'(m_addr)) else begin
      errors++;
      $error("[TB] FAIL %s address observed=%0d expected=%0d (edge %0d)", tag, row_address_out, m_addr, edge_n);
    end
    checks++;
    assert (row_out === m_row) else begin
      errors++;
      $error("[TB] FAIL %s row observed=%h expected=%h (edge %0d)", tag, row_out, m_row, edge_n);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check just after it.
  task automatic applyStimulus(input bit rst, input bit rdy, input int mode, input string tag);
    reset_in     = rst;
    row_ready_in = rdy;
    mode_in      = 4'(mode);
    @(posedge clk_in);
    edge_n++;
    if (rst) begin
      m_valid = 1'b0;
      m_addr  = 0;
      m_prev  = 0;
      m_entry = edge_n;
      m_row   = '0;
    end else begin
      if (mode != m_prev) m_addr = 0;
      else if (m_valid) m_addr = (m_addr + 1) % 16;
      if (mode != m_prev && mode == 8) m_entry = edge_n;
      m_valid = rdy;
      m_row   = exp_row(mode, ((edge_n - m_entry) / 64) % 64);
      m_prev  = mode;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int mode;
    bit rdy;
    int guard;

    // Reset held with ready high: everything stays zero.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 0, "reset_hold");

    // Free-running OFF mode: address counts through a full wrap.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 0, "off_count");

    // Modes 0..6, ten cycles each, ready toggling every cycle.
    for (int md = 0; md <= 6; md++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, 1'(i % 2 == 0), md, "mode_step");
        if (i == 0 && md != 0) begin
          checks++;
          assert (row_address_out === 4'd0) else begin
            errors++;
            $error("[TB] FAIL mode_change_addr observed=%0d expected=0", row_address_out);
          end
        end
      end
    end

    // Ready 1,0,1,0 in SOLID_RED.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'(i % 2 == 0), 1, "ready_toggle");

    // SCAN with ready held high long enough to see the column wrap.
    for (int i = 0; i < 10000; i++) applyStimulus(1'b0, 1'b1, 8, "scan");

    // Unused modes 7 and 15 render as OFF.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 7, "mode7");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 15, "mode15");

    // Mode 2 up to address 9, then a mid-stream reset.
    guard = 0;
    applyStimulus(1'b0, 1'b1, 2, "to_addr9");
    while (m_addr != 9 && guard < 40) begin
      applyStimulus(1'b0, 1'b1, 2, "to_addr9");
      guard++;
    end
    checks++;
    assert (row_address_out === 4'd9) else begin
      errors++;
      $error("[TB] FAIL reach_addr9 observed=%0d expected=9", row_address_out);
    end
    applyStimulus(1'b1, 1'b1, 2, "mid_reset");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 2, "after_reset");

    // Randomised modes, ready and occasional resets.
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) mode = $urandom_range(0, 15);
      if ($urandom_range(0, 99) < 2) mode = 8;
      rdy = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 199) == 0), rdy, mode, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
